// File: rtl/reuse_operand_sequencer_if.sv
// Operand stream bundle between the reuse sequencer, its operand RAM and the multiplier array.
// The master side is the sequencer; the slave side is the RAM/multiplier environment.
interface reuse_operand_sequencer_if #(
  parameter int BIT_WIDTH   = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int NUM_INPUTS  = 1 << SEL_WIDTH,
  parameter int ADDR_WIDTH  = 4,
  parameter int REUSE_WIDTH = 4
);
  logic                            i_start;
  logic [ADDR_WIDTH-1:0]           i_base_addr;
  logic [ADDR_WIDTH:0]             i_num_words;
  logic [REUSE_WIDTH-1:0]          i_reuse;
  logic [ADDR_WIDTH-1:0]           o_ram_addr;
  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_ram_data;
  logic                            o_valid;
  logic                            i_ready;
  logic [BIT_WIDTH-1:0]            o_data;
  logic [SEL_WIDTH-1:0]            o_lane;
  logic                            o_last;
  logic                            o_busy;
  logic                            o_done;

  modport master (
    input  i_start, i_base_addr, i_num_words, i_reuse, i_ram_data, i_ready,
    output o_ram_addr, o_valid, o_data, o_lane, o_last, o_busy, o_done
  );

  modport slave (
    output i_start, i_base_addr, i_num_words, i_reuse, i_ram_data, i_ready,
    input  o_ram_addr, o_valid, o_data, o_lane, o_last, o_busy, o_done
  );
endinterface

// File: rtl/reuse_operand_sequencer.sv
// Walks a run of wide RAM words and streams each lane element downstream,
// repeating every element a programmable number of times for multiplier reuse.
module reuse_operand_sequencer #(
  parameter int BIT_WIDTH   = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int NUM_INPUTS  = 1 << SEL_WIDTH,
  parameter int ADDR_WIDTH  = 4,
  parameter int REUSE_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  reuse_operand_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, READ, LOAD, EMIT, DONE} state_t;

  localparam logic [SEL_WIDTH-1:0]   SEL_MAX   = SEL_WIDTH'(NUM_INPUTS - 1);
  localparam logic [SEL_WIDTH-1:0]   SEL_ONE   = SEL_WIDTH'(1);
  localparam logic [REUSE_WIDTH-1:0] REUSE_ONE = REUSE_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]    CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                          state;
  logic [NUM_INPUTS*BIT_WIDTH-1:0] word_reg;
  logic [SEL_WIDTH-1:0]            sel;
  logic [REUSE_WIDTH-1:0]          rep_cnt;
  logic [ADDR_WIDTH:0]             word_cnt;
  logic [ADDR_WIDTH:0]             count_reg;
  logic [REUSE_WIDTH-1:0]          reuse_reg;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic                            valid_q;
  logic [BIT_WIDTH-1:0]            data_q;
  logic [SEL_WIDTH-1:0]            lane_q;
  logic                            last_q;
  logic                            busy_q;
  logic                            done_q;

  logic                            rep_wrap;
  logic                            sel_wrap;
  logic                            word_last;
  logic [REUSE_WIDTH-1:0]          rep_next;
  logic [SEL_WIDTH-1:0]            sel_next;
  logic                            next_last;
  logic                            load_last;
  logic                            run_end;
  logic                            word_end;

  function automatic logic [BIT_WIDTH-1:0] lane_of(
    input logic [NUM_INPUTS*BIT_WIDTH-1:0] word,
    input logic [SEL_WIDTH-1:0]            idx
  );
    return word[idx*BIT_WIDTH +: BIT_WIDTH];
  endfunction

  // Position of the beat that follows an accepted transfer, so outputs can be registered.
  always_comb begin
    rep_wrap  = (rep_cnt == reuse_reg - REUSE_ONE);
    sel_wrap  = (sel == SEL_MAX);
    word_last = (word_cnt == count_reg - CNT_ONE);
    rep_next  = rep_wrap ? '0 : rep_cnt + REUSE_ONE;
    sel_next  = sel;
    if (rep_wrap) begin
      sel_next = sel_wrap ? '0 : sel + SEL_ONE;
    end
    next_last = word_last && (sel_next == SEL_MAX) && (rep_next == reuse_reg - REUSE_ONE);
    load_last = word_last && (SEL_MAX == '0) && (reuse_reg == REUSE_ONE);
    run_end   = rep_wrap && sel_wrap && word_last;
    word_end  = rep_wrap && sel_wrap && !word_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_reg  <= '0;
      sel       <= '0;
      rep_cnt   <= '0;
      word_cnt  <= '0;
      count_reg <= '0;
      reuse_reg <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      lane_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            count_reg <= bus.i_num_words;
            reuse_reg <= (bus.i_reuse == '0) ? REUSE_ONE : bus.i_reuse;
            word_cnt  <= '0;
            busy_q    <= 1'b1;
            if (bus.i_num_words == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= READ;
              addr_q <= bus.i_base_addr;
            end
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          word_reg <= bus.i_ram_data;
          sel      <= '0;
          rep_cnt  <= '0;
          valid_q  <= 1'b1;
          data_q   <= lane_of(bus.i_ram_data, '0);
          lane_q   <= '0;
          last_q   <= load_last;
          state    <= EMIT;
        end
        EMIT: begin
          // Stalled beats keep every registered output untouched.
          if (bus.i_ready) begin
            rep_cnt <= rep_next;
            sel     <= sel_next;
            if (run_end) begin
              state   <= DONE;
              done_q  <= 1'b1;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else if (word_end) begin
              state    <= READ;
              word_cnt <= word_cnt + CNT_ONE;
              addr_q   <= addr_q + ADDR_ONE;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
            end else begin
              data_q <= lane_of(word_reg, sel_next);
              lane_q <= sel_next;
              last_q <= next_last;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ram_addr = addr_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_lane     = lane_q;
  assign bus.o_last     = last_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;

endmodule

// File: doc/reuse_operand_sequencer.md
Name: reuse_operand_sequencer

Overview:
Read-side sequencer for the multiplier-reuse stage. It walks a run of wide words in the single-port operand RAM, latches each word, and uses an internal NUM_INPUTS:1 lane mux to stream one BIT_WIDTH element per beat to the multiplier array. Each element is repeated a programmable number of times so one fetched operand is reused across several multiplies. It sits between the operand RAM and the multiplier stage, drives the RAM address, and presents a valid/ready stream downstream.

Parameters:
BIT_WIDTH, 16, width of one element
SEL_WIDTH, 4, lane-select width
NUM_INPUTS, 1<<SEL_WIDTH, elements per RAM word
ADDR_WIDTH, 4, RAM address width
REUSE_WIDTH, 4, width of the repeat count

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
i_start  input  1  one-cycle start request, sampled only in IDLE
i_base_addr  input  ADDR_WIDTH  first RAM word address
i_num_words  input  ADDR_WIDTH+1  words to stream
i_reuse  input  REUSE_WIDTH  beats per element; 0 is treated as 1
o_ram_addr  output  ADDR_WIDTH  RAM read address
i_ram_data  input  NUM_INPUTS*BIT_WIDTH  RAM read data, lane k at bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]
o_valid  output  1  element beat valid
i_ready  input  1  downstream accepts beat
o_data  output  BIT_WIDTH  current element
o_lane  output  SEL_WIDTH  lane index of o_data
o_last  output  1  final beat of the run, qualified by o_valid
o_busy  output  1  high whenever state is not IDLE
o_done  output  1  one-cycle completion pulse

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset values: every output is 0. State = IDLE. word_reg, sel, rep_cnt and word_cnt are all 0.
- States and transitions:
  - IDLE: on i_start, latch base, count and reuse (0 becomes 1). If count = 0, go to DONE. Otherwise go to READ.
  - READ (1 cycle): o_ram_addr holds the current address. The RAM registers its data on this cycle's closing edge. Go to LOAD.
  - LOAD (1 cycle): word_reg <= i_ram_data; sel <= 0; rep_cnt <= 0. Go to EMIT.
  - EMIT:
    - o_valid = 1, o_data = lane sel of word_reg, o_lane = sel.
    - A beat transfers on o_valid & i_ready. On a transfer:
      - If rep_cnt < reuse-1: rep_cnt++.
      - Else rep_cnt <= 0, then:
        - If sel < NUM_INPUTS-1: sel++.
        - Else if word_cnt < count-1: word_cnt++, address++, go to READ.
        - Else go to DONE.
  - DONE (1 cycle): o_done = 1. Go to IDLE.
- Latency: i_start sampled on edge E puts the first o_valid in the cycle after edge E+2. Each word boundary leaves a 2-cycle o_valid bubble (READ, LOAD).
- Handshake: while o_valid is high and i_ready is low, o_data, o_lane and o_last hold stable. o_valid never drops without a transfer. i_ready is ignored outside EMIT.
- o_last = EMIT & last word & sel = NUM_INPUTS-1 & rep_cnt = reuse-1.
- Address arithmetic is modulo 2^ADDR_WIDTH, so base = 2^ADDR_WIDTH-1 wraps to 0.
- o_ram_addr holds its last value outside READ.
- i_start while busy is ignored; parameters latched for the current run are unaffected.
- Total beats = count * NUM_INPUTS * max(reuse,1).
- rst asserted mid-run returns to IDLE on that edge, with all outputs 0 the next cycle. The sequencer issues no RAM write; RAM we is tied low externally.

Test Plan:
- Single word: RAM[2] lane k = 0x0100+k, base=2, num_words=1, reuse=1, i_ready=1 -> o_valid first high 3 cycles after start. 16 consecutive beats 0x0100..0x010F with o_lane 0..15. o_last on beat 16 only. o_done the cycle after, then o_busy=0.
- Reuse: same word, reuse=3 -> 48 beats, o_lane sequence 0,0,0,1,1,1,...,15,15,15. reuse=0 -> identical to reuse=1.
- Backpressure: reuse=1, i_ready held low for 5 cycles after beat 4, then toggled every cycle -> o_data/o_lane stable while stalled. Exactly 16 beats accepted, no duplicates or drops.
- Multi-word wrap: base=15, num_words=2, RAM[15] lanes = 0xA000+k, RAM[0] lanes = 0xB000+k -> o_ram_addr 15 then 0. 32 beats, with a 2-cycle o_valid gap between 0xA00F and 0xB000. o_last on 0xB00F.
- Zero length and busy start: num_words=0 -> o_done the cycle after start, o_valid never high, no READ. i_start pulsed mid-run -> ignored, run completes unchanged.
- Reset mid-run: rst after beat 5 -> next cycle o_valid=0, o_busy=0, o_ram_addr=0. A fresh start then streams the full run correctly from lane 0.
